// File: rtl/lcd_cmd_host.sv
// lcd_cmd_host: buffers upstream image commands in a FIFO, issues them one at a
// time on the controller's cmd/cmd_valid/busy handshake, and after the final
// write-back command (code 0) collects the IRAM write-back stream.
//
// Ports:
//   clk, reset         - rising-edge clock, asynchronous active-high reset
//   up_cmd/up_valid    - upstream command offer
//   up_ready           - block accepts up_cmd this cycle
//   cmd/cmd_valid      - command to the controller, single-cycle strobe
//   busy               - controller busy; low means it can take a command
//   IRAM_valid/D/A     - write-back byte strobe, data, address
//   done               - controller finished the write-back
//   sum/wr_cnt         - byte checksum and strobe count of the write-back
//   addr_err           - sticky address-sequence error
//   fin                - sticky session-complete flag
module lcd_cmd_host #(
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  up_cmd,
    input  logic        up_valid,
    output logic        up_ready,
    output logic [3:0]  cmd,
    output logic        cmd_valid,
    input  logic        busy,
    input  logic        IRAM_valid,
    input  logic [7:0]  IRAM_D,
    input  logic [5:0]  IRAM_A,
    input  logic        done,
    output logic [13:0] sum,
    output logic [6:0]  wr_cnt,
    output logic        addr_err,
    output logic        fin
);

    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned CMD_W   = 4;
    localparam int unsigned SUM_W   = 14;
    localparam int unsigned WCNT_W  = 7;

    typedef enum logic [2:0] {
        ST_WAIT_READY,
        ST_ISSUE,
        ST_WAIT_ACK,
        ST_DRAIN,
        ST_FIN
    } state_t;

    logic [CMD_W-1:0]  mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              closed_q;
    state_t            state_q;
    logic [CMD_W-1:0]  cmd_q;
    logic              cmd_valid_q;
    logic [SUM_W-1:0]  sum_q;
    logic [WCNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic              addr_err_q;
    logic              fin_q;

    logic fifo_full, fifo_empty, accept, push, pop;
    logic collect, addr_bad;

    // FIFO status and handshake
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign up_ready   = !fifo_full && !closed_q;
    assign accept     = up_valid && up_ready;
    // Codes 12..15 complete the handshake but are dropped
    assign push       = accept && (up_cmd[3:2] != 2'b11);
    // Head leaves the FIFO on the edge that enters ISSUE
    assign pop        = (state_q == ST_WAIT_READY) && !busy && !fifo_empty;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Write-back collection terms
    assign collect  = IRAM_valid && (state_q != ST_FIN);
    assign addr_bad = (IRAM_A != wr_cnt_q[5:0]) || (wr_cnt_q >= WCNT_W'(64))
                      || (state_q != ST_DRAIN);
    assign wr_cnt_d = (wr_cnt_q == WCNT_W'(127)) ? wr_cnt_q : wr_cnt_q + WCNT_W'(1);

    // FIFO storage, no reset needed on the data array
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= up_cmd;
        end
    end

    // FIFO pointers, occupancy and close flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            closed_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (up_cmd == '0) begin
                    closed_q <= 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Command-issue state machine with registered cmd/cmd_valid/fin
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_WAIT_READY;
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            fin_q       <= 1'b0;
        end else begin
            cmd_valid_q <= 1'b0;
            case (state_q)
                ST_WAIT_READY: begin
                    if (pop) begin
                        cmd_q       <= mem_q[rd_ptr_q];
                        cmd_valid_q <= 1'b1;
                        state_q     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    // cmd_q still holds the issued code
                    if (busy) begin
                        state_q <= (cmd_q == '0) ? ST_DRAIN : ST_WAIT_READY;
                    end
                end
                ST_DRAIN: begin
                    if (done) begin
                        state_q <= ST_FIN;
                        fin_q   <= 1'b1;
                    end
                end
                ST_FIN: begin
                    state_q <= ST_FIN;
                end
                default: begin
                    state_q <= ST_WAIT_READY;
                end
            endcase
        end
    end

    // Write-back checksum, count and address-sequence check
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q      <= '0;
            wr_cnt_q   <= '0;
            addr_err_q <= 1'b0;
        end else if (collect) begin
            sum_q    <= sum_q + SUM_W'(IRAM_D);
            wr_cnt_q <= wr_cnt_d;
            if (addr_bad) begin
                addr_err_q <= 1'b1;
            end
        end
    end

    assign cmd       = cmd_q;
    assign cmd_valid = cmd_valid_q;
    assign sum       = sum_q;
    assign wr_cnt    = wr_cnt_q;
    assign addr_err  = addr_err_q;
    assign fin       = fin_q;

endmodule

// File: tb/tb_lcd_cmd_host.sv
// tb_lcd_cmd_host: randomized self-checking bench for lcd_cmd_host with a
// queue-based reference model of the command path and arithmetic model of the
// write-back collection.
module tb_lcd_cmd_host;

    localparam int DEPTH     = 8;
    localparam int M_REACT   = 0;
    localparam int M_PATTERN = 1;
    localparam int M_HOLD    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  up_cmd;
    logic        up_valid;
    logic        up_ready;
    logic [3:0]  cmd;
    logic        cmd_valid;
    logic        busy;
    logic        IRAM_valid;
    logic [7:0]  IRAM_D;
    logic [5:0]  IRAM_A;
    logic        done;
    logic [13:0] sum;
    logic [6:0]  wr_cnt;
    logic        addr_err;
    logic        fin;

    lcd_cmd_host #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .up_cmd(up_cmd), .up_valid(up_valid),
        .up_ready(up_ready), .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy),
        .IRAM_valid(IRAM_valid), .IRAM_D(IRAM_D), .IRAM_A(IRAM_A), .done(done),
        .sum(sum), .wr_cnt(wr_cnt), .addr_err(addr_err), .fin(fin)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    // Reference model state
    int exp_q[$];       // commands believed to be queued in the DUT
    int exp_all[$];     // every command expected to be issued, in order
    int push_q[$];      // upstream stimulus not yet accepted
    int issued_log[$];  // commands observed on cmd_valid
    bit model_closed;
    int busy_mode;
    int hold;
    int ph;
    bit busy_seen;
    int nstrobe;
    int adj_viol;
    int ready_viol;

    function automatic logic [63:0] sig_of(input int q[$]);
        logic [63:0] s;
        s = '0;
        for (int i = 0; i < q.size(); i++) s = {s[59:0], 4'(q[i])};
        s[63:56] = s[63:56] ^ 8'(q.size());
        return s;
    endfunction

    task automatic clear_model();
        exp_q.delete(); exp_all.delete(); push_q.delete(); issued_log.delete();
        model_closed = 0; hold = 0; ph = 0; busy_seen = 0; nstrobe = 0;
        adj_viol = 0; ready_viol = 0; busy_mode = M_REACT;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; up_valid = 1'b0; up_cmd = '0; busy = 1'b0;
        IRAM_valid = 1'b0; IRAM_D = '0; IRAM_A = '0; done = 1'b0;
        clear_model();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One clock: observe at the falling edge, then drive controller and upstream
    task automatic tick();
        int c;
        @(posedge clk);
        @(negedge clk);
        if (cmd_valid === 1'b1) begin
            if (nstrobe > 0 && !busy_seen) adj_viol++;
            issued_log.push_back(int'(cmd));
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            busy_seen = 0;
            nstrobe++;
            if (busy_mode == M_REACT) hold = $urandom_range(4, 2);
        end
        if (up_ready !== ((exp_q.size() != DEPTH) && !model_closed)) ready_viol++;
        case (busy_mode)
            M_REACT: begin
                if (hold > 0) begin busy = 1'b1; hold--; end
                else busy = 1'b0;
            end
            M_PATTERN: begin
                ph = (ph + 1) % 3;
                busy = (ph != 0);
            end
            default: busy = 1'b1;
        endcase
        if (busy) busy_seen = 1;
        if (push_q.size() > 0) begin
            up_valid = 1'b1;
            up_cmd = 4'(push_q[0]);
            if (up_ready === 1'b1) begin
                c = push_q.pop_front();
                if (c < 12) begin exp_q.push_back(c); exp_all.push_back(c); end
                if (c == 0) model_closed = 1;
            end
        end else begin
            up_valid = 1'b0;
        end
    endtask

    task automatic wait_issued(input int max_cycles, output bit timed_out);
        int n;
        n = 0;
        while ((exp_q.size() > 0 || (push_q.size() > 0 && !model_closed)) && n < max_cycles) begin
            tick();
            n++;
        end
        timed_out = (n >= max_cycles);
    endtask

    task automatic test_reset();
        do_reset();
        busy = 1'b1; busy_mode = M_HOLD;
        push_q.push_back(6); push_q.push_back(0);
        repeat (4) tick();
        #2 reset = 1'b1;
        #1;
        checks++; if (up_ready !== 1'b1) $display("FAIL reset_up_ready: got %b want 1", up_ready); else passes++;
        checks++; if (cmd !== 4'd0) $display("FAIL reset_cmd: got %0d want 0", cmd); else passes++;
        checks++; if (cmd_valid !== 1'b0) $display("FAIL reset_cmd_valid: got %b want 0", cmd_valid); else passes++;
        checks++; if (sum !== 14'd0) $display("FAIL reset_sum: got %0d want 0", sum); else passes++;
        checks++; if (wr_cnt !== 7'd0) $display("FAIL reset_wr_cnt: got %0d want 0", wr_cnt); else passes++;
        checks++; if (addr_err !== 1'b0) $display("FAIL reset_addr_err: got %b want 0", addr_err); else passes++;
        checks++; if (fin !== 1'b0) $display("FAIL reset_fin: got %b want 0", fin); else passes++;
        @(negedge clk);
        reset = 1'b0; up_valid = 1'b0; busy = 1'b0;
        clear_model();
    endtask

    task automatic test_order();
        bit to;
        do_reset();
        busy_mode = M_PATTERN;
        push_q.push_back(3); push_q.push_back(8); push_q.push_back(0);
        wait_issued(200, to);
        repeat (4) tick();
        checks++; if (to) $display("FAIL order_timeout: commands still pending %0d want 0", exp_q.size()); else passes++;
        checks++; if (issued_log.size() != 3) $display("FAIL order_count: got %0d want 3", issued_log.size()); else passes++;
        checks++; if (sig_of(issued_log) !== sig_of(exp_all)) $display("FAIL order_seq: got %h want %h", sig_of(issued_log), sig_of(exp_all)); else passes++;
        checks++; if (adj_viol != 0) $display("FAIL order_spacing: got %0d adjacent strobes want 0", adj_viol); else passes++;
        checks++; if (ready_viol != 0) $display("FAIL order_ready: got %0d bad up_ready cycles want 0", ready_viol); else passes++;
        checks++; if (up_ready !== 1'b0) $display("FAIL order_closed: got up_ready %b want 0", up_ready); else passes++;
    endtask

    // Continues from test_order, which leaves the block in the drain phase
    task automatic test_writeback();
        busy_mode = M_REACT; hold = 0;
        for (int i = 0; i < 64; i++) begin
            IRAM_valid = 1'b1; IRAM_A = 6'(i); IRAM_D = 8'hFF;
            tick();
            if ($urandom_range(1, 0) == 1) begin IRAM_valid = 1'b0; tick(); end
        end
        IRAM_valid = 1'b0;
        tick();
        checks++; if (sum !== 14'd16320) $display("FAIL wb_sum: got %0d want 16320", sum); else passes++;
        checks++; if (wr_cnt !== 7'd64) $display("FAIL wb_wr_cnt: got %0d want 64", wr_cnt); else passes++;
        checks++; if (addr_err !== 1'b0) $display("FAIL wb_addr_err: got %b want 0", addr_err); else passes++;
        checks++; if (fin !== 1'b0) $display("FAIL wb_fin_early: got %b want 0", fin); else passes++;
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if (fin !== 1'b1) $display("FAIL wb_fin: got %b want 1", fin); else passes++;
        IRAM_valid = 1'b1; IRAM_A = 6'd0; IRAM_D = 8'h55;
        tick();
        IRAM_valid = 1'b0;
        tick();
        checks++; if (sum !== 14'd16320 || wr_cnt !== 7'd64) $display("FAIL fin_ignore: got sum %0d cnt %0d want 16320 64", sum, wr_cnt); else passes++;
        checks++; if (fin !== 1'b1) $display("FAIL fin_sticky: got %b want 1", fin); else passes++;
    endtask

    task automatic test_backpressure();
        bit to;
        do_reset();
        busy = 1'b1; busy_mode = M_HOLD;
        for (int i = 0; i < 9; i++) push_q.push_back($urandom_range(11, 1));
        repeat (15) tick();
        checks++; if (up_ready !== 1'b0) $display("FAIL bp_ready: got %b want 0", up_ready); else passes++;
        checks++; if (push_q.size() != 1) $display("FAIL bp_held: got %0d pending want 1", push_q.size()); else passes++;
        checks++; if (issued_log.size() != 0) $display("FAIL bp_no_issue: got %0d strobes want 0", issued_log.size()); else passes++;
        busy_mode = M_REACT; hold = 0;
        wait_issued(400, to);
        checks++; if (to) $display("FAIL bp_timeout: got %0d pending want 0", exp_q.size()); else passes++;
        checks++; if (sig_of(issued_log) !== sig_of(exp_all) || exp_all.size() != 9) $display("FAIL bp_order: got %h want %h", sig_of(issued_log), sig_of(exp_all)); else passes++;
        checks++; if (adj_viol != 0 || ready_viol != 0) $display("FAIL bp_protocol: got adj %0d ready %0d want 0 0", adj_viol, ready_viol); else passes++;
    endtask

    task automatic test_illegal_close();
        bit to;
        do_reset();
        push_q.push_back(13); push_q.push_back(5); push_q.push_back(0); push_q.push_back(2);
        wait_issued(200, to);
        repeat (8) tick();
        checks++; if (to) $display("FAIL ill_timeout: got %0d pending want 0", exp_q.size()); else passes++;
        checks++; if (issued_log.size() != 2) $display("FAIL ill_count: got %0d want 2", issued_log.size()); else passes++;
        checks++; if (sig_of(issued_log) !== sig_of(exp_all)) $display("FAIL ill_seq: got %h want %h", sig_of(issued_log), sig_of(exp_all)); else passes++;
        checks++; if (up_ready !== 1'b0 || push_q.size() != 1) $display("FAIL ill_closed: got ready %b pending %0d want 0 1", up_ready, push_q.size()); else passes++;
        checks++; if (ready_viol != 0 || adj_viol != 0) $display("FAIL ill_protocol: got ready %0d adj %0d want 0 0", ready_viol, adj_viol); else passes++;
        up_valid = 1'b0;
    endtask

    task automatic test_random_writeback();
        bit to;
        int n, m, a, d, es, ec;
        bit ee;
        do_reset();
        n = $urandom_range(7, 2);
        for (int i = 0; i < n; i++) push_q.push_back($urandom_range(15, 1));
        push_q.push_back(0);
        push_q.push_back($urandom_range(15, 1));
        wait_issued(400, to);
        repeat (8) tick();
        checks++; if (to) $display("FAIL rnd_timeout: got %0d pending want 0", exp_q.size()); else passes++;
        checks++; if (sig_of(issued_log) !== sig_of(exp_all)) $display("FAIL rnd_seq: got %h want %h", sig_of(issued_log), sig_of(exp_all)); else passes++;
        m = $urandom_range(70, 60);
        es = 0; ec = 0; ee = 0;
        for (int i = 0; i < m; i++) begin
            a = ($urandom_range(19, 0) == 0) ? $urandom_range(63, 0) : i % 64;
            d = $urandom_range(255, 0);
            if (a != ec % 64 || ec >= 64) ee = 1;
            es = (es + d) % 16384;
            if (ec < 127) ec++;
            IRAM_valid = 1'b1; IRAM_A = 6'(a); IRAM_D = 8'(d);
            tick();
        end
        IRAM_valid = 1'b0;
        tick();
        checks++; if (sum !== 14'(es)) $display("FAIL rnd_sum: got %0d want %0d", sum, es); else passes++;
        checks++; if (wr_cnt !== 7'(ec)) $display("FAIL rnd_wr_cnt: got %0d want %0d", wr_cnt, ec); else passes++;
        checks++; if (addr_err !== ee) $display("FAIL rnd_addr_err: got %b want %b", addr_err, ee); else passes++;
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++; if (fin !== 1'b1) $display("FAIL rnd_fin: got %b want 1", fin); else passes++;
    endtask

    task automatic test_fault_reset();
        bit to;
        int d0, d1, d2;
        do_reset();
        push_q.push_back(0);
        wait_issued(200, to);
        repeat (8) tick();
        checks++; if (to) $display("FAIL flt_timeout: got %0d pending want 0", exp_q.size()); else passes++;
        d0 = $urandom_range(255, 0); d1 = $urandom_range(255, 0); d2 = $urandom_range(255, 0);
        IRAM_valid = 1'b1; IRAM_A = 6'd0; IRAM_D = 8'(d0); tick();
        IRAM_A = 6'd1; IRAM_D = 8'(d1); tick();
        IRAM_valid = 1'b0;
        checks++; if (addr_err !== 1'b0) $display("FAIL flt_seq_ok: got %b want 0", addr_err); else passes++;
        IRAM_valid = 1'b1; IRAM_A = 6'd3; IRAM_D = 8'(d2); tick();
        IRAM_valid = 1'b0;
        checks++; if (addr_err !== 1'b1) $display("FAIL flt_addr_err: got %b want 1", addr_err); else passes++;
        checks++; if (sum !== 14'(d0 + d1 + d2) || wr_cnt !== 7'd3) $display("FAIL flt_totals: got %0d %0d want %0d 3", sum, wr_cnt, d0 + d1 + d2); else passes++;
        #2 reset = 1'b1;
        #1;
        checks++; if (addr_err !== 1'b0 || sum !== 14'd0 || wr_cnt !== 7'd0) $display("FAIL flt_reset_clear: got %b %0d %0d want 0 0 0", addr_err, sum, wr_cnt); else passes++;
        checks++; if (up_ready !== 1'b1 || fin !== 1'b0) $display("FAIL flt_reset_ready: got %b %b want 1 0", up_ready, fin); else passes++;
        @(negedge clk);
        reset = 1'b0; busy = 1'b0; up_valid = 1'b0;
        clear_model();
        // Issue latency from a fresh WAIT_READY
        checks++; if (up_ready !== 1'b1) $display("FAIL lat_ready: got %b want 1", up_ready); else passes++;
        up_valid = 1'b1; up_cmd = 4'd4;
        exp_q.push_back(4); exp_all.push_back(4);
        tick();
        checks++; if (cmd_valid !== 1'b0) $display("FAIL lat_early: got %b want 0", cmd_valid); else passes++;
        tick();
        checks++; if (cmd_valid !== 1'b1 || cmd !== 4'd4) $display("FAIL lat_issue: got %b cmd %0d want 1 4", cmd_valid, cmd); else passes++;
        tick();
        checks++; if (cmd_valid !== 1'b0 || cmd !== 4'd4) $display("FAIL lat_single: got %b cmd %0d want 0 4", cmd_valid, cmd); else passes++;
        // Stray strobe outside the drain phase
        IRAM_valid = 1'b1; IRAM_A = 6'd0; IRAM_D = 8'd7;
        tick();
        IRAM_valid = 1'b0;
        checks++; if (addr_err !== 1'b1 || sum !== 14'd7 || wr_cnt !== 7'd1) $display("FAIL stray_strobe: got %b %0d %0d want 1 7 1", addr_err, sum, wr_cnt); else passes++;
        checks++; if (ready_viol != 0) $display("FAIL flt_ready: got %0d bad cycles want 0", ready_viol); else passes++;
    endtask

    initial begin
        reset = 1'b1; up_valid = 1'b0; up_cmd = '0; busy = 1'b0;
        IRAM_valid = 1'b0; IRAM_D = '0; IRAM_A = '0; done = 1'b0;
        clear_model();
        test_reset();
        test_order();
        test_writeback();
        test_backpressure();
        test_illegal_close();
        test_random_writeback();
        test_fault_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/lcd_cmd_host.md
# lcd_cmd_host

Host-side counterpart of the LCD image controller. It buffers image-processing commands from an upstream sequencer and issues them one at a time on the controller's `cmd`/`cmd_valid`/`busy` handshake. After the final write command (code 0), it collects the 64-byte IRAM write-back stream, producing a byte checksum, a write count and an address-sequence error flag. It sits between the test/sequencing logic and the LCD controller and owns the command side of that interface.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: command FIFO entries, power of two, minimum 2.

Ports:
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `up_cmd`, input, 4: command code from the upstream sequencer.
- `up_valid`, input, 1: `up_cmd` is valid this cycle.
- `up_ready`, output, 1: the block accepts `up_cmd` this cycle. A transfer occurs when `up_valid && up_ready`.
- `cmd`, output, 4: command to the controller.
- `cmd_valid`, output, 1: single-cycle command strobe.
- `busy`, input, 1: controller busy. Low means the controller can take a command.
- `IRAM_valid`, input, 1: write-back byte strobe.
- `IRAM_D`, input, 8: write-back data.
- `IRAM_A`, input, 6: write-back address.
- `done`, input, 1: controller finished the write-back.
- `sum`, output, 14: running sum of the write-back bytes.
- `wr_cnt`, output, 7: number of write-back strobes received.
- `addr_err`, output, 1: sticky address-sequence error flag.
- `fin`, output, 1: sticky session-complete flag.

## Operation
- Command codes:
  - 0: write-back.
  - 1–4: move up, down, left, right.
  - 5–7: max, min, average.
  - 8–11: rotate CCW, rotate CW, mirror X, mirror Y.
  - 12–15: illegal. They are accepted upstream and discarded without being enqueued.
- FIFO:
  - Synchronous, `FIFO_DEPTH` entries, with a registered occupancy count.
  - `up_ready = (count != FIFO_DEPTH) && !closed`.
  - `closed` sets when code 0 is enqueued and stays set until reset, so nothing is accepted after the write-back command.
  - A push and a pop in the same cycle leave the count unchanged.
- State machine:
  - WAIT_READY → ISSUE, when `busy == 0` and the FIFO is not empty.
  - ISSUE → WAIT_ACK, always after one cycle. In ISSUE the block pops the FIFO head into `cmd` and drives `cmd_valid = 1`.
  - WAIT_ACK → WAIT_READY, when `busy == 1` is sampled and the issued code was not 0.
  - WAIT_ACK → DRAIN, when `busy == 1` is sampled and the issued code was 0.
  - DRAIN → FIN, when `done == 1` is sampled.
  - FIN is terminal until reset.
- `cmd` holds its last issued value between strobes. Its reset value is 0.
- Collection runs in every state except FIN. On each `IRAM_valid`:
  - `sum += IRAM_D`, 14-bit. The maximum legal total is 64 × 255 = 16320, so it never wraps.
  - `wr_cnt` increments, saturating at 127.
  - `addr_err` sets if `IRAM_A != wr_cnt[5:0]` (pre-increment value), or if `wr_cnt` is already 64.
- An `IRAM_valid` while not in DRAIN also sets `addr_err`.
- In FIN, `IRAM_valid` is ignored.
- `fin = 1` in FIN.

## Timing
- Reset values: `up_ready = 1`, `cmd = 0`, `cmd_valid = 0`, `sum = 0`, `wr_cnt = 0`, `addr_err = 0`, `fin = 0`. The FIFO is empty, `closed = 0`, and the state is WAIT_READY.
- Reset is asynchronous at any point, including mid-DRAIN. All outputs return to their reset values immediately, and queued commands are lost.
- Issue latency: `busy` sampled low with the FIFO non-empty at edge N gives `cmd_valid = 1` in cycle N+1, for exactly one cycle.
- Back-to-back command strobes are never adjacent. At least one cycle of `busy == 1` must be sampled between strobes. A controller that never raises `busy` leaves the block in WAIT_ACK indefinitely.
- Upstream enqueue latency: a command pushed at edge N is issuable from edge N+1. With an empty FIFO and `busy` low, `cmd_valid` asserts at the earliest in cycle N+2.
- `sum`, `wr_cnt` and `addr_err` update on the edge after the `IRAM_valid` sample.
- `fin` rises on the edge after `done` is sampled high in DRAIN.

## Test plan
- Reset check: assert `reset` asynchronously, mid-cycle → all outputs at their reset values before the next edge; `up_ready = 1`.
- Command ordering:
  - Stimulus: push 3, 8, 0; `busy` low for 1 cycle, high for 2, repeated.
  - Response: exactly three `cmd_valid` pulses carrying `cmd` 3, 8, 0 in order, each followed by at least one `busy`-high cycle; the state ends in DRAIN.
- Backpressure: hold `busy = 1` and push 9 legal non-zero codes → `up_ready` falls after the 8th; the 9th is held until one is issued; FIFO order is preserved.
- Illegal codes and close:
  - Stimulus: push 13, then 5, then 0, then 2.
  - Response: `cmd` 5 then 0 are issued; 13 is never issued; `up_ready = 0` after 0 is accepted; 2 is never accepted.
- Full write-back:
  - Stimulus: after code 0 is issued, drive 64 strobes with `IRAM_A` 0..63 and `IRAM_D = 0xFF`, then `done`.
  - Response: `sum = 16320`, `wr_cnt = 64`, `addr_err = 0`, and `fin = 1` one edge after `done`.
- Address fault and reset mid-DRAIN:
  - Stimulus: drive the sequence 0, 1, 3 → `addr_err = 1` after the third strobe.
  - Stimulus: assert `reset` → `addr_err`, `sum` and `wr_cnt` clear; state returns to WAIT_READY.
